// File: rtl/sound_sample_buffer_if.sv
// ============================================================================
// Module      : sound_sample_buffer_if
// Description : Loader-to-buffer write bus: load control, word writes, ack and
//               loader status levels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sound_sample_buffer_if;
  logic        load_start;
  logic [31:0] load_base;
  logic        ram_we;
  logic [31:0] ram_address;
  logic [15:0] ram_data;
  logic        ram_op_begun;
  logic        ram_init_done;
  logic        ram_init_error;

  modport master (
    output load_start, load_base, ram_we, ram_address, ram_data,
    output ram_init_done, ram_init_error,
    input  ram_op_begun
  );

  modport slave (
    input  load_start, load_base, ram_we, ram_address, ram_data,
    input  ram_init_done, ram_init_error,
    output ram_op_begun
  );
endinterface

`default_nettype wire

// File: rtl/sound_sample_buffer.sv
// ============================================================================
// Module      : sound_sample_buffer
// Description : BRAM sample store filled by the SD loader, played out as PCM at
//               one word per SAMPLE_DIV clocks. Define SOUND_BUF_LOOP_EN to loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_sample_buffer #(
  parameter int ADDR_W     = 15,
  parameter int SAMPLE_DIV = 1134
) (
  input  logic                   clk50,
  input  logic                   reset,
  sound_sample_buffer_if.slave   bus,
  input  logic                   play,
  input  logic                   stop,
  output logic [15:0]            sample_o,
  output logic                   sample_valid,
  output logic                   playing,
  output logic [ADDR_W:0]        loaded_len,
  output logic                   overflow,
  output logic                   load_error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LEN_W = ADDR_W + 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
`ifdef SOUND_BUF_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOADING = 3'd1;
  localparam logic [2:0] S_READY   = 3'd2;
  localparam logic [2:0] S_PLAYING = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  logic [2:0]        r_state, w_next;
  logic [31:0]       r_base;
  logic [31:0]       w_offset;
  logic              w_in_range, w_wr_accept, w_wr_en;
  logic [DIV_W-1:0]  r_div;
  logic              r_tick, r_rd_valid, r_rd_last;
  logic [ADDR_W-1:0] r_ptr;
  logic [15:0]       r_rd_data;
  logic              w_run, w_abort, w_emit, w_rd_issue, w_ptr_last;
  logic              w_op_begun_d, w_playing_d, w_error_d;
  logic [15:0]       mem [DEPTH];

  assign w_offset    = bus.ram_address - r_base;
  assign w_in_range  = (w_offset < 32'(DEPTH));
  // A write landing with load_start belongs to the load being abandoned.
  assign w_wr_accept = (r_state == S_LOADING) && bus.ram_op_begun && bus.ram_we && !bus.load_start;
  assign w_wr_en     = w_wr_accept && w_in_range;
  assign w_ptr_last  = ({1'b0, r_ptr} == (loaded_len - LEN_W'(1)));

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.load_start) w_next = S_LOADING;
      S_LOADING: begin
        if (bus.load_start)          w_next = S_LOADING;
        else if (bus.ram_init_error) w_next = S_ERROR;
        else if (bus.ram_init_done)  w_next = S_READY;
      end
      S_READY: begin
        if (bus.load_start)                        w_next = S_LOADING;
        else if (play && (loaded_len != '0))       w_next = S_PLAYING;
      end
      S_PLAYING: begin
        if (bus.load_start)                        w_next = S_LOADING;
        else if (stop)                             w_next = S_READY;
        else if (!LOOP_EN && r_rd_valid && r_rd_last) w_next = S_READY;
      end
      S_ERROR:   if (bus.load_start) w_next = S_LOADING;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_op_begun_d = (w_next == S_LOADING);
    w_playing_d  = (w_next == S_PLAYING);
    w_error_d    = (w_next == S_ERROR);
    w_abort      = (r_state == S_PLAYING) && (bus.load_start || stop);
    w_run        = (r_state == S_PLAYING) && (w_next == S_PLAYING);
    w_emit       = (r_state == S_PLAYING) && r_rd_valid && !w_abort;
    w_rd_issue   = w_run && r_tick;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      bus.ram_op_begun <= 1'b0;
      playing          <= 1'b0;
      load_error       <= 1'b0;
      r_base           <= '0;
      loaded_len       <= '0;
      overflow         <= 1'b0;
    end else begin
      bus.ram_op_begun <= w_op_begun_d;
      playing          <= w_playing_d;
      load_error       <= w_error_d;
      if (bus.load_start) begin
        r_base     <= bus.load_base;
        loaded_len <= '0;
        overflow   <= 1'b0;
      end else if (w_wr_accept) begin
        if (!w_in_range)                       overflow   <= 1'b1;
        else if (loaded_len != LEN_W'(DEPTH))  loaded_len <= loaded_len + LEN_W'(1);
      end
    end
  end

  // Divider tick is registered, then the read, then the output register:
  // first sample lands SAMPLE_DIV+2 clocks after play.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_div        <= '0;
      r_tick       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_ptr        <= '0;
      sample_o     <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (w_run) begin
        r_div      <= (r_div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : r_div + DIV_W'(1);
        r_tick     <= (r_div == DIV_W'(SAMPLE_DIV - 1));
        r_rd_valid <= w_rd_issue;
        if (w_rd_issue) begin
          r_rd_last <= w_ptr_last;
          r_ptr     <= (LOOP_EN && w_ptr_last) ? '0 : r_ptr + ADDR_W'(1);
        end
      end else begin
        r_div      <= '0;
        r_tick     <= 1'b0;
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
        r_ptr      <= '0;
      end
      sample_valid <= w_emit;
      if (w_emit)                     sample_o <= r_rd_data;
      else if (r_state != S_PLAYING)  sample_o <= '0;
    end
  end

  always_ff @(posedge clk50) begin
    if (w_wr_en)    mem[w_offset[ADDR_W-1:0]] <= bus.ram_data;
    if (w_rd_issue) r_rd_data <= mem[r_ptr];
  end

endmodule

`default_nettype wire

// File: tb/tb_sound_sample_buffer.sv
// ============================================================================
// Module      : tb_sound_sample_buffer
// Description : Scoreboard bench for sound_sample_buffer (ADDR_W=4, SAMPLE_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sound_sample_buffer;
  localparam int ADDR_W = 4;
  localparam int SDIV   = 4;
`ifdef SOUND_BUF_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct { int cyc; logic [15:0] data; } exp_t;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  logic play = 1'b0, stop = 1'b0;
  logic [15:0] sample_o;
  logic sample_valid, playing, overflow, load_error;
  logic [ADDR_W:0] loaded_len;

  sound_sample_buffer_if bus ();

  sound_sample_buffer #(.ADDR_W(ADDR_W), .SAMPLE_DIV(SDIV)) dut (
    .clk50(clk50), .reset(reset), .bus(bus.slave),
    .play(play), .stop(stop), .sample_o(sample_o), .sample_valid(sample_valid),
    .playing(playing), .loaded_len(loaded_len), .overflow(overflow), .load_error(load_error)
  );

  always #5 clk50 = ~clk50;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int pcyc;
  exp_t q[$];
  logic [15:0] img [4];

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk50) begin
    if (sample_valid) begin
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("sample_data", {16'h0, sample_o}, {16'h0, e.data});
        check("sample_time", cyc, e.cyc);
      end
    end
  end

  task automatic load_start_pulse(input logic [31:0] base);
    @(negedge clk50);
    bus.load_start = 1'b1; bus.load_base = base;
    @(negedge clk50);
    bus.load_start = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [15:0] data);
    @(negedge clk50);
    bus.ram_we = 1'b1; bus.ram_address = addr; bus.ram_data = data;
    @(negedge clk50);
    bus.ram_we = 1'b0;
  endtask

  task automatic finish_load(input logic err);
    @(negedge clk50);
    bus.ram_init_done = 1'b1; bus.ram_init_error = err;
    @(negedge clk50);
    bus.ram_init_done = 1'b0; bus.ram_init_error = 1'b0;
  endtask

  task automatic play_pulse(input logic with_stop);
    @(negedge clk50);
    play = 1'b1; stop = with_stop;
    @(posedge clk50);
    #1;
    play = 1'b0; stop = 1'b0;
    pcyc = cyc;
  endtask

  task automatic push_exp(input int k, input logic [15:0] d);
    exp_t e;
    e.cyc = pcyc + SDIV + 2 + SDIV * k;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk50);
    if (q.size() != 0) begin
      check("sb_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic play_and_check(input int len);
    int n;
    play_pulse(1'b0);
    n = LOOP ? len + 1 : len;
    for (int k = 0; k < n; k++) push_exp(k, img[k % len]);
    wait_sb(SDIV * n + 20);
    if (LOOP) begin
      @(negedge clk50); stop = 1'b1;
      @(negedge clk50); stop = 1'b0;
    end
    repeat (8) @(negedge clk50);
    check("end_playing", playing, 0);
    check("end_sample_o", sample_o, 0);
  endtask

  initial begin
    bus.load_start = 0; bus.load_base = 0; bus.ram_we = 0; bus.ram_address = 0;
    bus.ram_data = 0; bus.ram_init_done = 0; bus.ram_init_error = 0;
    repeat (3) @(negedge clk50);
    check("rst_op_begun", bus.ram_op_begun, 0);
    check("rst_sample_o", sample_o, 0);
    check("rst_playing", playing, 0);
    check("rst_loaded_len", loaded_len, 0);
    check("rst_overflow", overflow, 0);
    check("rst_load_error", load_error, 0);
    reset = 1'b0;

    play_pulse(1'b0);
    repeat (2) @(negedge clk50);
    check("idle_play_ignored", playing, 0);

    // basic load and playback
    img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333;
    load_start_pulse(32'h200);
    check("load_op_begun", bus.ram_op_begun, 1);
    for (int i = 0; i < 3; i++) write_word(32'h200 + i, img[i]);
    finish_load(1'b0);
    check("ready_op_begun", bus.ram_op_begun, 0);
    check("ready_len", loaded_len, 3);
    check("ready_overflow", overflow, 0);
    play_and_check(3);

    // out-of-range writes (above and below base)
    img[0] = 16'hAAAA;
    load_start_pulse(32'h200);
    check("reload_len_cleared", loaded_len, 0);
    write_word(32'h200, img[0]);
    write_word(32'h210, 16'hBEEF);
    check("ovf_set", overflow, 1);
    check("ovf_len", loaded_len, 1);
    write_word(32'h1FF, 16'hDEAD);
    check("ovf_below_len", loaded_len, 1);
    finish_load(1'b0);
    play_and_check(1);
    load_start_pulse(32'h0);
    check("ovf_cleared", overflow, 0);

    // error has priority over done
    finish_load(1'b1);
    check("err_load_error", load_error, 1);
    check("err_op_begun", bus.ram_op_begun, 0);
    play_pulse(1'b0);
    repeat (2) @(negedge clk50);
    check("err_play_ignored", playing, 0);
    load_start_pulse(32'h0);
    check("err_exit_load_error", load_error, 0);
    check("err_exit_op_begun", bus.ram_op_begun, 1);
    finish_load(1'b0);
    play_pulse(1'b0);
    repeat (2) @(negedge clk50);
    check("empty_play_ignored", playing, 0);

    // stop and play together while playing
    img[0] = 16'h0102; img[1] = 16'h0304; img[2] = 16'h0506; img[3] = 16'h0708;
    load_start_pulse(32'h40);
    for (int i = 0; i < 4; i++) write_word(32'h40 + i, img[i]);
    finish_load(1'b0);
    check("four_len", loaded_len, 4);
    play_pulse(1'b0);
    check("playing_set", playing, 1);
    push_exp(0, img[0]);
    wait_sb(SDIV + 10);
    @(negedge clk50); stop = 1'b1; play = 1'b1;
    @(negedge clk50); stop = 1'b0; play = 1'b0;
    check("stop_playing", playing, 0);
    repeat (3 * SDIV) @(negedge clk50);
    check("stop_sample_o", sample_o, 0);
    check("stop_playing_late", playing, 0);

    // reset between BRAM read and sample output
    play_pulse(1'b0);
    repeat (SDIV + 1) @(posedge clk50);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_sample_o", sample_o, 0);
    check("midrst_valid", sample_valid, 0);
    check("midrst_playing", playing, 0);
    check("midrst_len", loaded_len, 0);
    check("midrst_op_begun", bus.ram_op_begun, 0);
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    repeat (3 * SDIV) @(negedge clk50);
    check("postrst_playing", playing, 0);
    check("postrst_sample_o", sample_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
